// File: rtl/sfp_norm_if.sv
// ============================================================================
// Module : sfp_norm_if
// Brief  : Row/sum/result bundle between the PSUM memory side and sfp_norm.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface sfp_norm_if #(
    parameter int COL     = 8,
    parameter int BW_PSUM = 19,
    parameter int SUM_BW  = BW_PSUM + 3
);
    logic [COL*BW_PSUM-1:0] sfp_in;
    logic                   acc;
    logic                   div;
    logic                   ext_en;
    logic [SUM_BW-1:0]      sum_in;
    logic [SUM_BW-1:0]      sum_out;
    logic                   sum_valid;
    logic                   busy;
    logic [COL*BW_PSUM-1:0] sfp_out;
    logic                   out_valid;

    modport master (
        output sfp_in, acc, div, ext_en, sum_in,
        input  sum_out, sum_valid, busy, sfp_out, out_valid
    );

    modport slave (
        input  sfp_in, acc, div, ext_en, sum_in,
        output sum_out, sum_valid, busy, sfp_out, out_valid
    );
endinterface

`default_nettype wire

// File: rtl/sfp_norm.sv
// ============================================================================
// Module : sfp_norm
// Brief  : Row abs-sum plus per-element normalisation by bit-serial division.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sfp_norm #(
    parameter int COL     = 8,
    parameter int BW_PSUM = 19,
    parameter int SUM_BW  = BW_PSUM + 3,
    parameter int FRAC    = 8
) (
    input  logic       clk,
    input  logic       reset,
    sfp_norm_if.slave  bus
);
    localparam int DW = BW_PSUM + FRAC;
    localparam int CW = $clog2(DW);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACC   = 3'd1,
        S_READY = 3'd2,
        S_DIV   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 r_state;
    logic [BW_PSUM-1:0]     r_row [COL];
    logic [SUM_BW-1:0]      r_sum;
    logic [SUM_BW:0]        r_den;
    logic [COL-1:0]         r_neg;
    logic [DW-1:0]          r_dq  [COL];
    logic [SUM_BW:0]        r_rem [COL];
    logic [CW-1:0]          r_cnt;
    logic                   r_sum_valid;
    logic                   r_busy;
    logic [COL*BW_PSUM-1:0] r_sfp_out;
    logic                   r_out_valid;

    logic [BW_PSUM-1:0]     w_mag    [COL];
    logic [DW-1:0]          w_dq_nx  [COL];
    logic [SUM_BW:0]        w_rem_nx [COL];
    logic [BW_PSUM-1:0]     w_res    [COL];
    logic [SUM_BW-1:0]      w_sum;
    logic [SUM_BW:0]        w_den;

    // r_dq holds the dividend being shifted out at the top while quotient
    // bits enter at the bottom, so after DW steps it is the full quotient.
    genvar gi;
    generate
        for (gi = 0; gi < COL; gi++) begin : g_lane
            logic [SUM_BW+1:0]  w_rs;
            logic               w_ge;
            logic [BW_PSUM-1:0] w_q;

            assign w_mag[gi]    = r_row[gi][BW_PSUM-1] ? -r_row[gi] : r_row[gi];
            assign w_rs         = {r_rem[gi], r_dq[gi][DW-1]};
            assign w_ge         = (w_rs >= {1'b0, r_den});
            assign w_rem_nx[gi] = w_ge ? (w_rs[SUM_BW:0] - r_den) : w_rs[SUM_BW:0];
            assign w_dq_nx[gi]  = {r_dq[gi][DW-2:0], w_ge};
            assign w_q          = w_dq_nx[gi][BW_PSUM-1:0];
            assign w_res[gi]    = r_neg[gi] ? -w_q : w_q;
        end
    endgenerate

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < COL; i++) begin
            w_sum = w_sum + SUM_BW'(w_mag[i]);
        end
    end

    assign w_den = {1'b0, r_sum} + (bus.ext_en ? {1'b0, bus.sum_in} : '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_sum       <= '0;
            r_den       <= '0;
            r_neg       <= '0;
            r_cnt       <= '0;
            r_sum_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_sfp_out   <= '0;
            r_out_valid <= 1'b0;
            for (int i = 0; i < COL; i++) begin
                r_row[i] <= '0;
                r_dq[i]  <= '0;
                r_rem[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.acc) begin
                        for (int i = 0; i < COL; i++)
                            r_row[i] <= bus.sfp_in[i*BW_PSUM +: BW_PSUM];
                        r_sum_valid <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_ACC;
                    end
                end
                S_ACC: begin
                    r_sum       <= w_sum;
                    r_sum_valid <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_READY;
                end
                S_READY: begin
                    if (bus.acc) begin
                        for (int i = 0; i < COL; i++)
                            r_row[i] <= bus.sfp_in[i*BW_PSUM +: BW_PSUM];
                        r_sum_valid <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_ACC;
                    end else if (bus.div) begin
                        if (w_den == '0) begin
                            // Nothing to divide by: report an all-zero row at once.
                            r_sfp_out   <= '0;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_den <= w_den;
                            for (int i = 0; i < COL; i++) begin
                                r_neg[i] <= r_row[i][BW_PSUM-1];
                                r_dq[i]  <= {w_mag[i], {FRAC{1'b0}}};
                                r_rem[i] <= '0;
                            end
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= S_DIV;
                        end
                    end
                end
                S_DIV: begin
                    for (int i = 0; i < COL; i++) begin
                        r_dq[i]  <= w_dq_nx[i];
                        r_rem[i] <= w_rem_nx[i];
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(DW - 1)) begin
                        for (int i = 0; i < COL; i++)
                            r_sfp_out[i*BW_PSUM +: BW_PSUM] <= w_res[i];
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.sum_out   = r_sum;
    assign bus.sum_valid = r_sum_valid;
    assign bus.busy      = r_busy;
    assign bus.sfp_out   = r_sfp_out;
    assign bus.out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_sfp_norm.sv
// ============================================================================
// Module : tb_sfp_norm
// Brief  : Directed self-checking bench for sfp_norm.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sfp_norm;
    localparam int COL     = 8;
    localparam int BW_PSUM = 19;
    localparam int SUM_BW  = 22;
    localparam int FRAC    = 8;
    localparam int W       = COL * BW_PSUM;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   n;

    sfp_norm_if #(.COL(COL), .BW_PSUM(BW_PSUM), .SUM_BW(SUM_BW)) bus_if ();

    sfp_norm #(.COL(COL), .BW_PSUM(BW_PSUM), .SUM_BW(SUM_BW), .FRAC(FRAC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] pack8(input int a, input int b, input int c, input int d,
                                           input int e, input int f, input int g, input int h);
        int v [8];
        logic [W-1:0] r;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        v[4] = e; v[5] = f; v[6] = g; v[7] = h;
        r = '0;
        for (int i = 0; i < COL; i++) r[i*BW_PSUM +: BW_PSUM] = BW_PSUM'(v[i]);
        return r;
    endfunction

    function automatic logic [W-1:0] rep(input int v);
        return pack8(v, v, v, v, v, v, v, v);
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_acc(input logic [W-1:0] row, input string tag, input int exp_sum);
        bus_if.sfp_in = row;
        bus_if.acc    = 1'b1;
        step();
        bus_if.acc    = 1'b0;
        chk({tag, "_busy_acc"}, bus_if.busy, 1);
        step();
        chk({tag, "_sum_valid"}, bus_if.sum_valid, 1);
        chk({tag, "_sum_out"}, bus_if.sum_out, exp_sum);
    endtask

    task automatic run_div(input logic ext, input logic [SUM_BW-1:0] s, output int cnt);
        bus_if.div    = 1'b1;
        bus_if.ext_en = ext;
        bus_if.sum_in = s;
        step();
        bus_if.div    = 1'b0;
        bus_if.ext_en = 1'b0;
        bus_if.sum_in = '0;
        cnt = 1;
        while (!bus_if.out_valid && cnt < 40) begin
            step();
            cnt++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset         = 1'b0;
        bus_if.sfp_in = '0;
        bus_if.acc    = 1'b0;
        bus_if.div    = 1'b0;
        bus_if.ext_en = 1'b0;
        bus_if.sum_in = '0;
        repeat (3) step();
        chk("rst_sum_out", bus_if.sum_out, 0);
        chk("rst_sum_valid", bus_if.sum_valid, 0);
        chk("rst_busy", bus_if.busy, 0);
        chk("rst_out_valid", bus_if.out_valid, 0);
        chk("rst_sfp_out", bus_if.sfp_out, 0);
        reset = 1'b1;
        step();

        // div while idle must do nothing
        bus_if.div = 1'b1;
        step();
        bus_if.div = 1'b0;
        chk("idle_div_busy", bus_if.busy, 0);
        step();
        step();
        chk("idle_div_out_valid", bus_if.out_valid, 0);
        chk("idle_div_sum_valid", bus_if.sum_valid, 0);

        // all +1, local sum only: 256/8 = 32
        do_acc(rep(1), "ones", 8);
        chk("ones_busy_ready", bus_if.busy, 0);
        run_div(1'b0, '0, n);
        chk("ones_latency", n, 28);
        chk("ones_out", bus_if.sfp_out, rep(32));

        // back-to-back: acc in DONE drops both valids
        bus_if.sfp_in = pack8(4, -4, 0, 0, 0, 0, 0, 0);
        bus_if.acc    = 1'b1;
        step();
        bus_if.acc    = 1'b0;
        chk("b2b_out_valid_drop", bus_if.out_valid, 0);
        chk("b2b_sum_valid_drop", bus_if.sum_valid, 0);
        step();
        chk("pm4_sum_out", bus_if.sum_out, 8);
        run_div(1'b0, '0, n);
        chk("pm4_latency", n, 28);
        chk("pm4_out", bus_if.sfp_out, pack8(128, -128, 0, 0, 0, 0, 0, 0));

        // partner sums widen the divisor
        do_acc(rep(1), "ext8", 8);
        run_div(1'b1, 22'd8, n);
        chk("ext8_out", bus_if.sfp_out, rep(16));
        do_acc(rep(1), "ext24", 8);
        run_div(1'b1, 22'd24, n);
        chk("ext24_out", bus_if.sfp_out, rep(8));

        // most negative psum
        do_acc(pack8(-262144, 0, 0, 0, 0, 0, 0, 0), "minneg", 262144);
        run_div(1'b0, '0, n);
        chk("minneg_out", bus_if.sfp_out, pack8(-256, 0, 0, 0, 0, 0, 0, 0));

        // zero divisor finishes in one edge
        do_acc(rep(0), "zero", 0);
        run_div(1'b1, '0, n);
        chk("zero_latency", n, 1);
        chk("zero_out", bus_if.sfp_out, 0);

        // acc during DIV is ignored
        do_acc(rep(1), "accdiv", 8);
        bus_if.div = 1'b1;
        step();
        bus_if.div = 1'b0;
        n = 1;
        while (!bus_if.out_valid && n < 40) begin
            if (n == 5) begin
                bus_if.sfp_in = rep(2);
                bus_if.acc    = 1'b1;
            end
            step();
            bus_if.acc = 1'b0;
            n++;
        end
        chk("accdiv_latency", n, 28);
        chk("accdiv_out", bus_if.sfp_out, rep(32));
        chk("accdiv_sum_out", bus_if.sum_out, 8);

        // acc and div together in READY: acc wins
        do_acc(rep(1), "both_pre", 8);
        bus_if.sfp_in = pack8(1, 2, 3, 4, 0, 0, 0, 0);
        bus_if.acc    = 1'b1;
        bus_if.div    = 1'b1;
        step();
        bus_if.acc    = 1'b0;
        bus_if.div    = 1'b0;
        chk("both_busy", bus_if.busy, 1);
        chk("both_sum_valid", bus_if.sum_valid, 0);
        step();
        chk("both_sum_out", bus_if.sum_out, 10);
        repeat (5) step();
        chk("both_no_div", bus_if.busy, 0);

        // reset pulse in the middle of a division
        bus_if.div = 1'b1;
        step();
        bus_if.div = 1'b0;
        n = 1;
        while (n < 10) begin
            step();
            n++;
        end
        chk("mid_busy_before", bus_if.busy, 1);
        reset = 1'b0;
        #2;
        chk("mid_rst_sfp_out", bus_if.sfp_out, 0);
        chk("mid_rst_sum_out", bus_if.sum_out, 0);
        chk("mid_rst_out_valid", bus_if.out_valid, 0);
        chk("mid_rst_busy", bus_if.busy, 0);
        chk("mid_rst_sum_valid", bus_if.sum_valid, 0);
        step();
        reset = 1'b1;
        step();
        bus_if.div = 1'b1;
        step();
        bus_if.div = 1'b0;
        chk("post_rst_div_busy", bus_if.busy, 0);
        repeat (30) step();
        chk("post_rst_div_out_valid", bus_if.out_valid, 0);
        do_acc(pack8(1, 2, 3, 4, 0, 0, 0, 0), "post_rst", 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/sfp_norm.md
Name: sfp_norm

Overview:
- Special-function stage directly downstream of the PSUM memory.
- Takes one row of col signed partial sums read from PSUM memory and computes their absolute-value sum.
- Exports that sum to the partner core and accepts the partner's sum.
- Normalizes every element by the total using a bit-serial restoring divider: out = sign(x) * floor((|x| << frac) / total). The result is the row written back to PSUM memory.

Parameters:
col, 8, number of psum elements per row
bw_psum, 19, width of each signed psum element
sum_bw, 22 (bw_psum+3), width of the unsigned row sum exchanged between cores
frac, 8, fraction bits of the normalized output

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
sfp_in  input  col*bw_psum  row of signed psums; element i at [bw_psum*(i+1)-1 : bw_psum*i]
acc  input  1  load sfp_in and start the sum (single-cycle pulse)
div  input  1  start normalization (single-cycle pulse)
ext_en  input  1  include sum_in in the divisor; sampled with div
sum_in  input  sum_bw  partner core's row sum, unsigned
sum_out  output  sum_bw  this row's absolute-value sum
sum_valid  output  1  sum_out valid
busy  output  1  high in ACC and DIV
sfp_out  output  col*bw_psum  normalized signed row, same packing as sfp_in
out_valid  output  1  sfp_out valid

Behaviour:
- Reset (asserted low) asynchronously clears the FSM to IDLE and zeroes all outputs and internal registers: sfp_out=0, sum_out=0, sum_valid=0, busy=0, out_valid=0. This applies mid-operation; any in-flight division is discarded.
- FSM states: IDLE, ACC, READY, DIV, DONE.
- IDLE -> ACC on acc: row_reg <= sfp_in.
- ACC -> READY after 1 cycle:
  - sum_reg <= sum of |row_reg[i]|, unsigned, sum_bw bits.
  - |x| of -2^(bw_psum-1) equals 2^(bw_psum-1), with no overflow.
- READY:
  - sum_out = sum_reg and sum_valid = 1. Both hold until the next acc or reset.
- READY -> DIV on div:
  - Latch divisor D = sum_reg + (ext_en ? sum_in : 0) in sum_bw+1 bits.
  - Latch signs and magnitudes.
  - Clear the iteration counter.
- READY -> DONE instead when D == 0: sfp_out = all zeros.
- DIV:
  - col parallel restoring dividers share D.
  - Dividend width is DW = bw_psum+frac (27 by default), consumed one bit per cycle, MSB first.
  - Exactly DW cycles, then DONE.
  - Quotient is truncated (floor). Because D >= |x|, quotient <= 2^frac.
  - Result is negated (two's complement) when x < 0, then sign-extended to bw_psum.
- DONE: out_valid = 1. sfp_out holds until the next acc or reset.
- DONE -> ACC on acc.
- Latency:
  - acc sampled at edge 1 -> sum_valid high after edge 2.
  - div sampled at edge 1 -> out_valid high after edge DW+1 (28 by default).
  - With D == 0, out_valid is high after edge 1.
- acc handling by state:
  - READY or DONE: accepted and restarts (ACC); sum_valid and out_valid drop.
  - ACC or DIV: ignored.
- div is ignored in every state except READY.
- acc and div together in READY: acc wins and div is dropped.
- sum_in is sampled only on the div-accepting edge.

Test Plan:
- Row all +1, ext_en=0: sum_out=8; sfp_out every element = 32 (256/8); out_valid after 28 edges from div.
- Row [4, -4, 0, 0, 0, 0, 0, 0], ext_en=0: sum_out=8; sfp_out=[128, -128, 0, 0, 0, 0, 0, 0].
- Row all +1, ext_en=1, sum_in=8: D=16; every element = 16. Repeat with sum_in=24: D=32, every element = 8.
- Row element0 = -2^18, rest 0: sum_out=262144; element0 = -256.
- All-zero row with sum_in=0: out_valid one edge after div; sfp_out=0.
- Boundary and control cases, each checked as follows:
  - div issued in IDLE: ignored, state unchanged.
  - acc during DIV: ignored; result completes unchanged.
  - acc and div in the same READY cycle: new row loads.
  - reset pulse at DIV cycle 10: all outputs 0, state IDLE.
  - Back-to-back rows: second acc in DONE drops out_valid.
